arb_pkt_mux: RTL and testbench
==============================

Name: arb_pkt_mux

Overview:
- Downstream consumer of the round-robin arbiter.
- Drives the arbiter's request vector from N packet sources and takes back the one-hot grant.
- Locks onto the granted source for a whole packet, up to and including its last beat, and forwards beats through a single-entry registered output stage with valid/ready handshake.
- Sits between the N requesters and a shared downstream sink.

Parameters:
- N, 4, number of sources; must match the arbiter's N.
- W, 8, data width per beat.
- CW, 8, width of the per-packet beat counter; saturates at the maximum value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-source beat valid.
- in_data  input  N*W  per-source data; source i occupies bits [i*W +: W].
- in_last  input  N  per-source last-beat marker.
- in_ready  output  N  per-source beat accept.
- arb_req  output  N  request vector to the arbiter.
- arb_grant  input  N  one-hot grant from the arbiter (combinational from arb_req); all-zero means no grant.
- out_valid  output  1  output beat valid.
- out_data  output  W  output beat data.
- out_last  output  1  output last-beat marker.
- out_ready  input  1  downstream accept.
- busy  output  1  high while in LOCKED.
- lock_idx  output  $clog2(N)  index of the locked source; holds its last value when IDLE.
- beat_cnt  output  CW  beats accepted in the current or most recent packet.
- grant_err  output  1  sticky error flag, cleared only by rst.

Behaviour:
- Reset (async, rst=1) clears:
  - state to IDLE;
  - lock_ff, lock_idx, beat_cnt, grant_err, out_valid, out_data and out_last to 0.
- in_ready is combinationally 0 while rst is asserted.
- State machine has two states, IDLE and LOCKED.
- IDLE:
  - arb_req = in_valid; in_ready = 0.
  - On a clock edge where arb_grant is exactly one-hot and in_valid at the granted bit is 1:
    - lock_ff <= arb_grant;
    - lock_idx <= encoded index;
    - beat_cnt <= 0;
    - state <= LOCKED.
  - If arb_grant has more than one bit set, or grants a source whose in_valid=0: no lock, grant_err <= 1, remain IDLE.
  - All-zero grant: remain IDLE with no error.
- LOCKED:
  - arb_req = 0, so the arbiter sees no requests and does not re-grant mid-packet; arb_grant is ignored.
  - Let k be the locked source. in_ready[k] = !out_valid | out_ready; all other in_ready bits = 0.
  - A beat is accepted when in_valid[k] & in_ready[k]. On acceptance:
    - out_data <= in_data[k], out_last <= in_last[k], out_valid <= 1;
    - beat_cnt increments and saturates at 2^CW-1.
  - Accepting a beat with in_last[k]=1 sets state <= IDLE on the same edge. The beat remains in the output register until it is drained.
  - An in_valid[k]=0 bubble mid-packet: the lock is held, nothing is loaded, and beat_cnt is unchanged.
- Output register:
  - When out_valid & out_ready and no new beat is accepted on that edge, out_valid <= 0.
  - Simultaneous drain and accept loads the new beat with no bubble, giving 1 beat/cycle throughput.
  - out_data and out_last hold their values while out_valid & !out_ready.
- Latency:
  - Grant seen at edge t; first in_ready at cycle t+1.
  - A beat accepted at edge e appears on out_valid from cycle e+1.
  - Minimum gap between packets is one IDLE cycle, used for arbitration.
- Back-to-back packets: after the last beat, IDLE re-arbitrates using the current in_valid. The arbiter's own mask provides fairness.
- Reset mid-packet: immediate return to IDLE; any output beat in flight is dropped and out_valid=0.

Test Plan:
- Single packet: N=4, in_valid=4'b0100, source 2 sends 3 beats 0xA1,0xA2,0xA3 with last on the 3rd, out_ready=1, arbiter grants 4'b0100. Required:
  - out_data sequence A1,A2,A3 with out_last only on A3;
  - lock_idx=2, beat_cnt=3;
  - busy falls on the edge that accepts A3.
- Lock hold: sources 0 and 1 both valid, grant 4'b0001. Required:
  - arb_req=0 and in_ready[1]=0 for the whole packet from source 0, including a 2-cycle bubble on in_valid[0];
  - source 1 is granted only in the IDLE cycle after source 0's last beat.
- Backpressure: out_ready=0 for 5 cycles mid-packet. Required:
  - out_data stable and in_ready[k]=0 while out_valid=1;
  - no beat lost or duplicated after out_ready returns to 1;
  - throughput is 1 beat/cycle once flowing.
- Bad grant: force arb_grant=4'b0011, then arb_grant=4'b1000 with in_valid[3]=0. Required:
  - grant_err=1 and remains 1;
  - state stays IDLE; busy=0.
- Reset mid-packet: assert rst while out_valid=1 in the 2nd beat. Required:
  - out_valid=0, busy=0, beat_cnt=0 and in_ready=0 immediately;
  - a new grant after release locks normally.
- Saturation: CW=2, send a 6-beat packet. Required: beat_cnt reaches 3 and holds at 3; all 6 beats are forwarded.

Source files
------------

// File: rtl/arb_pkt_mux.sv
// Packet-locking multiplexer behind a round-robin arbiter. It passes the source
// requests to the arbiter. When the arbiter grants a source, the mux locks onto
// that source until its last beat. Beats go out through a one-entry registered
// output stage that uses a valid/ready handshake.
module arb_pkt_mux #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic [N-1:0]         arb_req,
    input  logic [N-1:0]         arb_grant,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [$clog2(N)-1:0] lock_idx,
    output logic [CW-1:0]        beat_cnt,
    output logic                 grant_err
);

    localparam int IW = $clog2(N);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]   state;
    logic [N-1:0] lock_ff;

    logic          grant_onehot;
    logic          grant_hit;
    logic [IW-1:0] grant_idx;
    logic          sel_valid;
    logic [W-1:0]  sel_data;
    logic          sel_last;
    logic          take_ready;
    logic          accept;

    // Check the grant and encode it into an index. A grant counts only when it is one-hot and the granted source is valid.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no path leaves it unassigned and infers a latch.
        grant_idx    = '0;
        grant_onehot = (arb_grant != '0) && ((arb_grant & (arb_grant - 1'b1)) == '0);
        grant_hit    = |(arb_grant & in_valid);
        for (int i = 0; i < N; i++) begin
            if (arb_grant[i]) grant_idx = IW'(i);
        end
    end

    // Select the valid, data and last signals of the locked source using the one-hot lock mask.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (lock_ff[i]) begin
                sel_valid = in_valid[i];
                sel_data  = in_data[i*W +: W];
                sel_last  = in_last[i];
            end
        end
    end

    // Handshake signals. The locked source may send when the output register is empty or is draining on this cycle.
    always_comb begin
        take_ready = !out_valid || out_ready;
        busy       = (state == ST_LOCKED);
        accept     = busy && sel_valid && take_ready;
        arb_req    = busy ? '0 : in_valid;
        // rst gates in_ready directly so that no source sees an accept while reset is held.
        in_ready   = (rst || !busy) ? '0 : (lock_ff & {N{take_ready}});
    end

    // State machine, lock capture, beat counter, sticky error flag and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lock_ff   <= '0;
            lock_idx  <= '0;
            beat_cnt  <= '0;
            grant_err <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every register then samples its pre-edge value, whatever the statement order.
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (arb_grant != '0) begin
                        if (grant_onehot && grant_hit) begin
                            lock_ff  <= arb_grant;
                            lock_idx <= grant_idx;
                            beat_cnt <= '0;
                            state    <= ST_LOCKED;
                        end else begin
                            grant_err <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (accept) begin
                        if (beat_cnt != {CW{1'b1}}) beat_cnt <= beat_cnt + CW'(1);
                        if (sel_last) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb_pkt_mux.sv
// Directed testbench for arb_pkt_mux (N=4, W=8, CW=2). The bench plays the role of the arbiter.
// A per-cycle vector table covers a single packet, lock hold, backpressure and bad grants.
// Hand-written sequences cover reset in the middle of a packet and beat-counter saturation.
module tb_arb_pkt_mux;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   arb_req;
    logic [N-1:0]   arb_grant;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic           busy;
    logic [1:0]     lock_idx;
    logic [CW-1:0]  beat_cnt;
    logic           grant_err;

    int checks = 0;
    int errors = 0;

    arb_pkt_mux #(.N(N), .W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .arb_req(arb_req), .arb_grant(arb_grant),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .lock_idx(lock_idx), .beat_cnt(beat_cnt), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] iv;
        logic [3:0] gnt;
        int         src;
        logic [7:0] d;
        logic [3:0] lst;
        logic       ordy;
        logic [3:0] rdy;
        logic [3:0] req;
        logic       ov;
        logic [7:0] od;
        logic       ol;
        logic       bsy;
        logic [1:0] idx;
        logic [1:0] cnt;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Put data d on the lane of source src, and a distinct filler byte on every other lane.
    function automatic logic [N*W-1:0] mk(input int src, input logic [7:0] d);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = (i == src) ? d : 8'(8'h50 + i);
        return r;
    endfunction

    function automatic vec_t v(input logic [3:0] iv, input logic [3:0] gnt, input int src,
                               input logic [7:0] d, input logic [3:0] lst, input logic ordy,
                               input logic [3:0] rdy, input logic [3:0] req, input logic ov,
                               input logic [7:0] od, input logic ol, input logic bsy,
                               input logic [1:0] idx, input logic [1:0] cnt, input logic err);
        vec_t r;
        r.iv = iv; r.gnt = gnt; r.src = src; r.d = d; r.lst = lst; r.ordy = ordy;
        r.rdy = rdy; r.req = req; r.ov = ov; r.od = od; r.ol = ol; r.bsy = bsy;
        r.idx = idx; r.cnt = cnt; r.err = err;
        return r;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 4'b1111; in_data = '0; in_last = '0; arb_grant = 4'b0001; out_ready = 1'b1;

        // Per-cycle vectors. The expected values show the registered state from the previous edge and the combinational response to this cycle's inputs.
        //                   iv       gnt    src  d      lst   ordy  rdy      req     ov  od     ol bsy idx cnt err
        // Single packet from source 2.
        tbl.push_back(v(4'b0100, 4'b0100, 2, 8'hA1, 4'b0000, 1, 4'b0000, 4'b0100, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(v(4'b0100, 4'b0100, 2, 8'hA1, 4'b0000, 1, 4'b0100, 4'b0000, 0, 8'h00, 0, 1, 2, 0, 0));
        tbl.push_back(v(4'b0100, 4'b0100, 2, 8'hA2, 4'b0000, 1, 4'b0100, 4'b0000, 1, 8'hA1, 0, 1, 2, 1, 0));
        tbl.push_back(v(4'b0100, 4'b0100, 2, 8'hA3, 4'b0100, 1, 4'b0100, 4'b0000, 1, 8'hA2, 0, 1, 2, 2, 0));
        tbl.push_back(v(4'b0000, 4'b0000, 2, 8'h00, 4'b0000, 1, 4'b0000, 4'b0000, 1, 8'hA3, 1, 0, 2, 3, 0));
        tbl.push_back(v(4'b0000, 4'b0000, 2, 8'h00, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'hA3, 1, 0, 2, 3, 0));
        // Lock hold: source 0 is locked, a 2-cycle bubble follows, and source 1 is granted only after source 0 ends.
        tbl.push_back(v(4'b0011, 4'b0001, 0, 8'hB1, 4'b0000, 1, 4'b0000, 4'b0011, 0, 8'hA3, 1, 0, 2, 3, 0));
        tbl.push_back(v(4'b0011, 4'b0010, 0, 8'hB1, 4'b0000, 1, 4'b0001, 4'b0000, 0, 8'hA3, 1, 1, 0, 0, 0));
        tbl.push_back(v(4'b0010, 4'b0010, 0, 8'hB2, 4'b0000, 1, 4'b0001, 4'b0000, 1, 8'hB1, 0, 1, 0, 1, 0));
        tbl.push_back(v(4'b0010, 4'b0010, 0, 8'hB2, 4'b0000, 1, 4'b0001, 4'b0000, 0, 8'hB1, 0, 1, 0, 1, 0));
        tbl.push_back(v(4'b0011, 4'b0010, 0, 8'hB2, 4'b0001, 1, 4'b0001, 4'b0000, 0, 8'hB1, 0, 1, 0, 1, 0));
        tbl.push_back(v(4'b0010, 4'b0010, 1, 8'hC1, 4'b0000, 1, 4'b0000, 4'b0010, 1, 8'hB2, 1, 0, 0, 2, 0));
        tbl.push_back(v(4'b0010, 4'b0010, 1, 8'hC1, 4'b0010, 1, 4'b0010, 4'b0000, 0, 8'hB2, 1, 1, 1, 0, 0));
        tbl.push_back(v(4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 1, 4'b0000, 4'b0000, 1, 8'hC1, 1, 0, 1, 1, 0));
        // Backpressure on source 3: out_ready is held low for 5 cycles.
        tbl.push_back(v(4'b1000, 4'b1000, 3, 8'hD1, 4'b0000, 1, 4'b0000, 4'b1000, 0, 8'hC1, 1, 0, 1, 1, 0));
        tbl.push_back(v(4'b1000, 4'b1000, 3, 8'hD1, 4'b0000, 0, 4'b1000, 4'b0000, 0, 8'hC1, 1, 1, 3, 0, 0));
        tbl.push_back(v(4'b1000, 4'b1000, 3, 8'hD2, 4'b0000, 0, 4'b0000, 4'b0000, 1, 8'hD1, 0, 1, 3, 1, 0));
        tbl.push_back(v(4'b1000, 4'b1000, 3, 8'hD2, 4'b0000, 0, 4'b0000, 4'b0000, 1, 8'hD1, 0, 1, 3, 1, 0));
        tbl.push_back(v(4'b1000, 4'b1000, 3, 8'hD2, 4'b0000, 0, 4'b0000, 4'b0000, 1, 8'hD1, 0, 1, 3, 1, 0));
        tbl.push_back(v(4'b1000, 4'b1000, 3, 8'hD2, 4'b0000, 0, 4'b0000, 4'b0000, 1, 8'hD1, 0, 1, 3, 1, 0));
        tbl.push_back(v(4'b1000, 4'b1000, 3, 8'hD2, 4'b0000, 1, 4'b1000, 4'b0000, 1, 8'hD1, 0, 1, 3, 1, 0));
        tbl.push_back(v(4'b1000, 4'b1000, 3, 8'hD3, 4'b1000, 1, 4'b1000, 4'b0000, 1, 8'hD2, 0, 1, 3, 2, 0));
        tbl.push_back(v(4'b0000, 4'b0000, 3, 8'h00, 4'b0000, 1, 4'b0000, 4'b0000, 1, 8'hD3, 1, 0, 3, 3, 0));
        tbl.push_back(v(4'b0000, 4'b0000, 3, 8'h00, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'hD3, 1, 0, 3, 3, 0));
        // Bad grants: a multi-hot grant, then a grant to an idle source. A clean grant after them still locks.
        tbl.push_back(v(4'b0011, 4'b0011, 0, 8'h00, 4'b0000, 1, 4'b0000, 4'b0011, 0, 8'hD3, 1, 0, 3, 3, 0));
        tbl.push_back(v(4'b0011, 4'b1000, 0, 8'h00, 4'b0000, 1, 4'b0000, 4'b0011, 0, 8'hD3, 1, 0, 3, 3, 1));
        tbl.push_back(v(4'b0011, 4'b0000, 0, 8'h00, 4'b0000, 1, 4'b0000, 4'b0011, 0, 8'hD3, 1, 0, 3, 3, 1));
        tbl.push_back(v(4'b0001, 4'b0001, 0, 8'hE1, 4'b0000, 1, 4'b0000, 4'b0001, 0, 8'hD3, 1, 0, 3, 3, 1));
        tbl.push_back(v(4'b0001, 4'b0001, 0, 8'hE1, 4'b0001, 1, 4'b0001, 4'b0000, 0, 8'hD3, 1, 1, 0, 0, 1));
        tbl.push_back(v(4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 1, 4'b0000, 4'b0000, 1, 8'hE1, 1, 0, 0, 1, 1));

        // Reset state, checked while rst is held and every source is requesting.
        @(posedge clk); @(posedge clk); #1;
        check("rst in_ready", in_ready, 4'b0000);
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_data", out_data, 8'h00);
        check("rst out_last", out_last, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst lock_idx", lock_idx, 2'd0);
        check("rst beat_cnt", beat_cnt, 2'd0);
        check("rst grant_err", grant_err, 1'b0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            in_valid  = tbl[i].iv;
            arb_grant = tbl[i].gnt;
            in_data   = mk(tbl[i].src, tbl[i].d);
            in_last   = tbl[i].lst;
            out_ready = tbl[i].ordy;
            #2;
            check($sformatf("v%0d in_ready", i), in_ready, tbl[i].rdy);
            check($sformatf("v%0d arb_req", i), arb_req, tbl[i].req);
            check($sformatf("v%0d out_valid", i), out_valid, tbl[i].ov);
            check($sformatf("v%0d out_data", i), out_data, tbl[i].od);
            check($sformatf("v%0d out_last", i), out_last, tbl[i].ol);
            check($sformatf("v%0d busy", i), busy, tbl[i].bsy);
            check($sformatf("v%0d lock_idx", i), lock_idx, tbl[i].idx);
            check($sformatf("v%0d beat_cnt", i), beat_cnt, tbl[i].cnt);
            check($sformatf("v%0d grant_err", i), grant_err, tbl[i].err);
            @(posedge clk); #1;
        end

        // Reset while the 2nd beat of a packet is in flight.
        in_valid = 4'b0100; arb_grant = 4'b0100; in_data = mk(2, 8'hF1); in_last = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("mid lock busy", busy, 1'b1);
        @(posedge clk); #1;
        in_data = mk(2, 8'hF2);
        check("mid first beat out_valid", out_valid, 1'b1);
        check("mid first beat out_data", out_data, 8'hF1);
        rst = 1'b1;
        #1;
        check("mid rst out_valid", out_valid, 1'b0);
        check("mid rst busy", busy, 1'b0);
        check("mid rst beat_cnt", beat_cnt, 2'd0);
        check("mid rst in_ready", in_ready, 4'b0000);
        check("mid rst grant_err", grant_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 4'b0010; arb_grant = 4'b0010; in_data = mk(1, 8'hC7); in_last = 4'b0010;
        #1;
        check("post rst arb_req", arb_req, 4'b0010);
        @(posedge clk); #1;
        check("post rst busy", busy, 1'b1);
        check("post rst lock_idx", lock_idx, 2'd1);
        check("post rst in_ready", in_ready, 4'b0010);
        @(posedge clk); #1;
        check("post rst out_valid", out_valid, 1'b1);
        check("post rst out_data", out_data, 8'hC7);
        check("post rst out_last", out_last, 1'b1);
        check("post rst busy low", busy, 1'b0);
        check("post rst beat_cnt", beat_cnt, 2'd1);
        // A grant to a source whose in_valid is 0 raises the error flag from a clean state.
        in_valid = 4'b0011; arb_grant = 4'b1000; in_last = '0;
        @(posedge clk); #1;
        check("idle grant err", grant_err, 1'b1);
        check("idle grant busy", busy, 1'b0);
        in_valid = '0; arb_grant = '0;
        @(posedge clk); #1;
        check("idle grant err sticky", grant_err, 1'b1);

        // Saturation: a 6-beat packet with CW=2. The counter stops at 3 and every beat is still forwarded.
        in_valid = 4'b0001; arb_grant = 4'b0001; out_ready = 1'b1;
        @(posedge clk); #1;
        check("sat lock busy", busy, 1'b1);
        check("sat lock beat_cnt", beat_cnt, 2'd0);
        for (int b = 0; b < 6; b++) begin
            in_data = mk(0, 8'(8'h31 + b));
            in_last = (b == 5) ? 4'b0001 : 4'b0000;
            #1;
            check($sformatf("sat b%0d in_ready", b), in_ready, 4'b0001);
            @(posedge clk); #1;
            check($sformatf("sat b%0d out_valid", b), out_valid, 1'b1);
            check($sformatf("sat b%0d out_data", b), out_data, 8'(8'h31 + b));
            check($sformatf("sat b%0d out_last", b), out_last, (b == 5) ? 1'b1 : 1'b0);
            check($sformatf("sat b%0d beat_cnt", b), beat_cnt, (b >= 2) ? 2'd3 : 2'(b + 1));
        end
        in_valid = '0; arb_grant = '0; in_last = '0;
        check("sat end busy", busy, 1'b0);
        @(posedge clk); #1;
        check("sat drained out_valid", out_valid, 1'b0);
        check("sat hold beat_cnt", beat_cnt, 2'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
